// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared widths and vector types for the 8-bit rotate datapath
package barrel_pkg;
  localparam int DATA_W  = 8;
  localparam int SHIFT_W = 3;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SHIFT_W-1:0] shamt_t;
endpackage

// File: rtl/rot_stage.sv
// rtl/rot_stage.sv - one stage of the log rotate network: rotate left by K when sel is set
module rot_stage
  import barrel_pkg::*;
#(
  parameter int K = 1
) (
  input  logic [DATA_W-1:0] din,
  input  logic              sel,
  output logic [DATA_W-1:0] dout
);

  data_t rotated;

  assign rotated = {din[DATA_W-1-K:0], din[DATA_W-1:DATA_W-K]};
  assign dout    = sel ? rotated : din;

endmodule

// File: rtl/barrel_shifter8_reg.sv
// rtl/barrel_shifter8_reg.sv - registered 8-bit left rotate by a 3-bit amount, scalar bit ports
module barrel_shifter8_reg
  import barrel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic A5,
  input  logic A6,
  input  logic A7,
  input  logic S0,
  input  logic S1,
  input  logic S2,
  output logic Vout0,
  output logic Vout1,
  output logic Vout2,
  output logic Vout3,
  output logic Vout4,
  output logic Vout5,
  output logic Vout6,
  output logic Vout7
);

  data_t  a_vec;
  shamt_t s_vec;
  data_t  st0_out;
  data_t  st1_out;
  data_t  st2_out;
  data_t  v_d;
  data_t  v_q;

  assign a_vec = {A7, A6, A5, A4, A3, A2, A1, A0};
  assign s_vec = {S2, S1, S0};

  // Distances 1, 2, 4 each gated by one amount bit sum to any rotate 0..7.
  rot_stage #(.K(1)) u_stage0 (.din(a_vec),   .sel(s_vec[0]), .dout(st0_out));
  rot_stage #(.K(2)) u_stage1 (.din(st0_out), .sel(s_vec[1]), .dout(st1_out));
  rot_stage #(.K(4)) u_stage2 (.din(st1_out), .sel(s_vec[2]), .dout(st2_out));

  always_comb begin
    v_d = st2_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  assign Vout0 = v_q[0];
  assign Vout1 = v_q[1];
  assign Vout2 = v_q[2];
  assign Vout3 = v_q[3];
  assign Vout4 = v_q[4];
  assign Vout5 = v_q[5];
  assign Vout6 = v_q[6];
  assign Vout7 = v_q[7];

endmodule

// File: tb/tb_barrel_shifter8_reg.sv
// tb/tb_barrel_shifter8_reg.sv - self-checking bench for barrel_shifter8_reg
module tb_barrel_shifter8_reg;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [2:0] s;
  wire  [7:0] v;

  int n_checks;
  int n_fail;
  int prev_exp;

  barrel_shifter8_reg dut (
    .clk  (clk),
    .rst  (rst),
    .A0   (a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .A4   (a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
    .S0   (s[0]), .S1(s[1]), .S2(s[2]),
    .Vout0(v[0]), .Vout1(v[1]), .Vout2(v[2]), .Vout3(v[3]),
    .Vout4(v[4]), .Vout5(v[5]), .Vout6(v[6]), .Vout7(v[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate as arithmetic on an integer, wrapping the bits that leave the top.
  function automatic int ref_rotl(input int val, input int amt);
    int wide;
    wide = val * (1 << amt);
    return (wide % 256) + (wide / 256);
  endfunction

  task automatic check(input string tag, input int expected);
    logic [7:0] exp8;
    exp8 = expected[7:0];
    n_checks++;
    assert (v === exp8)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, v, exp8);
    end
  endtask

  // Called just after a rising edge: drives inputs, confirms the register still holds
  // the previous result, then checks the new result one edge later.
  task automatic apply(input string tag, input int aval, input int sval);
    int expected;
    a = aval[7:0];
    s = sval[2:0];
    expected = ref_rotl(aval, sval);
    #1;
    check({tag, "_hold"}, prev_exp);
    @(posedge clk);
    #1;
    check(tag, expected);
    prev_exp = expected;
  endtask

  initial begin
    int ra;
    int rs;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    a   = 8'h00;
    s   = 3'd0;

    #2 rst = 1'b1;
    #1 check("reset_async", 0);
    @(posedge clk); #1 check("reset_hold0", 0);
    a = 8'hFF; s = 3'd3;
    @(posedge clk); #1 check("reset_hold1", 0);
    rst = 1'b0;
    prev_exp = 0;

    apply("pass_s0", 'hDC, 0);
    apply("dc_s1",   'hDC, 1);
    apply("dc_s4",   'hDC, 4);
    apply("dc_s5",   'hDC, 5);
    apply("dc_s6",   'hDC, 6);
    apply("dc_s7",   'hDC, 7);
    check("dc_s7_const", 'h6E);

    for (int i = 0; i < 8; i++) begin
      apply($sformatf("walk_s%0d", i), 'h01, i);
      check($sformatf("walk_onehot_s%0d", i), 1 << i);
    end

    for (int i = 0; i < 4; i++) apply($sformatf("walk2_s%0d", i), 'h01, i);
    a = 8'h01;
    s = 3'd3;
    #1 rst = 1'b1;
    #1 check("midrst_async", 0);
    #3 rst = 1'b0;
    #1 check("midrst_hold", 0);
    @(posedge clk); #1 check("midrst_release", 'h08);
    prev_exp = 'h08;

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 7));
      apply($sformatf("rand%0d", i), ra, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
